dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data RAM (ram.v, 2**N x 32, sync read) between two requesters:
//   m0 = core load/store unit (priority), m1 = DMA/program loader.
//   One grant per cycle, fully pipelined, with a starvation guard for m1.
//   Misaligned or out-of-range accesses are blocked from the RAM and answered with an error.
//   Sits between the requesters and ram; drives ram we/mem_ctrl/address/data_in.
// PARAMETERS
//   N         8   RAM word-address width; valid byte addresses are 0 .. 4*2**N-1
//   MAX_WAIT  4   consecutive lost cycles after which a waiting m1 is granted (1..15)
// PORTS
//   clk            in   1   system clock, all state on posedge
//   rst            in   1   asynchronous, active-high reset
//   mX_req         in   1   X in {0,1}: access request, held until mX_gnt
//   mX_we          in   1   1 = store, 0 = load
//   mX_size        in   2   `STORE_B / `STORE_HW / `STORE_W encoding (also used for loads)
//   mX_addr        in   32  byte address
//   mX_wdata       in   32  store data, right-aligned (byte in [7:0], halfword in [15:0])
//   mX_gnt         out  1   comb.: request accepted this cycle
//   mX_rvalid      out  1   reg: load data / error response valid (one-cycle pulse)
//   mX_rdata       out  32  raw RAM word for the completed load; 0 on error
//   mX_err         out  1   reg: qualifies mX_rvalid; access was rejected
//   ram_we         out  1   to ram.we
//   ram_mem_ctrl   out  2   to ram.mem_ctrl
//   ram_addr       out  32  to ram.address
//   ram_wdata      out  32  to ram.data_in
//   ram_rdata      in   32  from ram.data_out
// BEHAVIOUR
//   Reset (async): mX_rvalid=0, mX_err=0, mX_rdata=0, wait_cnt=0, rd_owner/rd_pend/err_pend=0.
//     While rst is high, mX_gnt=0 and ram_we=0. Responses in flight at reset are dropped.
//   Arbitration (comb., same cycle):
//     - m1 wins if m1_req && (!m0_req || wait_cnt==MAX_WAIT); otherwise m0 wins if m0_req.
//     - Exactly one gnt per cycle at most.
//     - wait_cnt: +1 (saturating) when m1_req && !m1_gnt; cleared when m1_gnt or !m1_req.
//   Illegal access:
//     - size==`STORE_HW with addr[1:0]==2'b11, or size==`STORE_W with addr[1:0]!=0,
//       or addr[31:2] >= 2**N.
//     - Still granted, but ram_we=0 and the RAM address is forced to 0.
//     - Next cycle the granted master sees rvalid=1, err=1, rdata=0.
//     - Applies to loads and stores.
//   Legal store:
//     - ram_we=1, ram_mem_ctrl=size, ram_addr=addr, ram_wdata=wdata in the grant cycle.
//     - RAM lane placement is done by the RAM; no rvalid is generated.
//   Legal load:
//     - ram_we=0, ram_addr=addr in the grant cycle.
//     - Cycle+1: owner's rvalid=1, rdata=ram_rdata (full word, err=0); the other master's rvalid=0.
//     - Load latency is exactly 1 cycle after gnt.
//   Idle cycle (no gnt): ram_we=0, ram_addr/ram_mem_ctrl/ram_wdata hold the last granted
//     values (no RAM glitch); no rvalid next cycle.
//   Back-to-back:
//     - A new grant is allowed every cycle, including in the cycle a load response returns.
//     - Store at t followed by load of the same word at t+1 returns the stored data at t+2.
//   rdata/err of a master hold their last value when rvalid=0.
// TESTING
//   1 Reset: assert rst mid-load (gnt at t, rst at t+0.5) -> no rvalid at t+1; all outputs 0.
//   2 m0 SW 0xDEADBEEF @0x10, then LW @0x10 -> m0_rvalid one cycle after 2nd gnt, rdata=0xDEADBEEF.
//   3 m0 SB 0xAA @0x11 over word 0x11223344 at 0x10, LW @0x10 -> 0x1122AA44.
//   4 m0_req and m1_req held high for 10 cycles, MAX_WAIT=4 -> m1_gnt on cycles 5 and 10 only;
//     wait_cnt never exceeds 4.
//   5 SH @0x13 and LW @0x4*2**N -> gnt, ram_we=0, next cycle rvalid=1, err=1, rdata=0; RAM unchanged.
//   6 Interleave: m1 LW @0x20 at t, m0 LW @0x24 at t+1 -> m1_rvalid at t+1, m0_rvalid at t+2,
//     each with its own word; no crossed responses.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: m0 (LSU) has priority, m1 (DMA) is
// protected from starvation. Misaligned or out-of-range accesses never reach the RAM.
module dmem_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        ram_we,
  output logic [1:0]  ram_mem_ctrl,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  // Access size encoding shared with the RAM's mem_ctrl input.
  localparam logic [1:0]  SizeHw    = 2'd1;
  localparam logic [1:0]  SizeW     = 2'd2;
  localparam logic [3:0]  MaxWait   = 4'(MAX_WAIT);
  localparam logic [32:0] WordLimit = 33'(1) << N;

  logic [3:0]  wait_q, wait_d;
  logic        any_gnt;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        illegal;
  logic        rsp;

  logic [31:0] addr_q;
  logic [1:0]  ctrl_q;
  logic [31:0] wdata_q;

  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] hold0_q, hold1_q;

  // Arbitration: m1 only overrides a competing m0 once it has lost MaxWait cycles in a row.
  always_comb begin
    m1_gnt = 1'b0;
    m0_gnt = 1'b0;
    if (!rst) begin
      m1_gnt = m1_req && (!m0_req || (wait_q == MaxWait));
      m0_gnt = m0_req && !m1_gnt;
    end
    any_gnt = m0_gnt || m1_gnt;
  end

  always_comb begin
    wait_d = 4'd0;
    if (m1_req && !m1_gnt) begin
      wait_d = (wait_q == 4'hf) ? 4'hf : wait_q + 4'd1;
    end
  end

  always_comb begin
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_size  = m1_gnt ? m1_size  : m0_size;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
  end

  always_comb begin
    illegal = 1'b0;
    if ((sel_size == SizeHw) && (sel_addr[1:0] == 2'b11)) begin
      illegal = 1'b1;
    end
    if ((sel_size == SizeW) && (sel_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
    if ({3'b000, sel_addr[31:2]} >= WordLimit) begin
      illegal = 1'b1;
    end
  end

  // Idle cycles replay the last granted bus so the RAM inputs never glitch.
  always_comb begin
    ram_we       = 1'b0;
    ram_addr     = addr_q;
    ram_mem_ctrl = ctrl_q;
    ram_wdata    = wdata_q;
    if (any_gnt) begin
      ram_we       = sel_we && !illegal;
      ram_addr     = illegal ? 32'd0 : sel_addr;
      ram_mem_ctrl = sel_size;
      ram_wdata    = sel_wdata;
    end
  end

  // Loads and every rejected access produce a response in the following cycle.
  always_comb begin
    rsp      = any_gnt && (illegal || !sel_we);
    rvalid_d = {m1_gnt && rsp, m0_gnt && rsp};
    err_d    = err_q;
    if (rvalid_d[0]) begin
      err_d[0] = illegal;
    end
    if (rvalid_d[1]) begin
      err_d[1] = illegal;
    end
  end

  // The RAM read port is synchronous, so the response word is its current output.
  always_comb begin
    m0_rvalid = rvalid_q[0];
    m1_rvalid = rvalid_q[1];
    m0_err    = err_q[0];
    m1_err    = err_q[1];
    m0_rdata  = hold0_q;
    m1_rdata  = hold1_q;
    if (rvalid_q[0]) begin
      m0_rdata = err_q[0] ? 32'd0 : ram_rdata;
    end
    if (rvalid_q[1]) begin
      m1_rdata = err_q[1] ? 32'd0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q   <= 4'd0;
      addr_q   <= 32'd0;
      ctrl_q   <= 2'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      hold0_q  <= 32'd0;
      hold1_q  <= 32'd0;
    end else begin
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      if (any_gnt) begin
        addr_q  <= ram_addr;
        ctrl_q  <= ram_mem_ctrl;
        wdata_q <= ram_wdata;
      end
      if (rvalid_q[0]) begin
        hold0_q <= m0_rdata;
      end
      if (rvalid_q[1]) begin
        hold1_q <= m1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM plus a byte-level reference memory and
// request-level arbitration model, driven by directed steps and random traffic.
module tb_dmem_arbiter;

  localparam int unsigned N        = 8;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned WORDS    = 1 << N;
  localparam logic [1:0]  SZ_B     = 2'd0;
  localparam logic [1:0]  SZ_HW    = 2'd1;
  localparam logic [1:0]  SZ_W     = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [1:0]  ram_mem_ctrl;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .ram_we(ram_we), .ram_mem_ctrl(ram_mem_ctrl), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: synchronous read, byte lanes placed from the low address bits.
  logic [31:0] mem [0:WORDS-1] = '{default: 32'd0};
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if ((ram_mem_ctrl == SZ_W) ||
            ((ram_mem_ctrl == SZ_HW) && (b == ram_addr[1:0] || b == ram_addr[1:0] + 1)) ||
            ((ram_mem_ctrl == SZ_B) && (b == ram_addr[1:0]))) begin
          mem[ram_addr[N+1:2]][8*b +: 8] <= ram_wdata[8*(b - ram_addr[1:0]) +: 8];
        end
      end
    end
    ram_rdata <= mem[ram_addr[N+1:2]];
  end

  // Reference state
  logic [7:0]  ref_mem [0:4*WORDS-1] = '{default: 8'd0};
  int          wait_m;
  logic [31:0] last_addr;
  logic        exp_rv  [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];
  logic        t_req   [2];
  logic        t_we    [2];
  logic [1:0]  t_size  [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic        obs_g1;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] size, input logic [31:0] addr);
    if (addr / 4 >= WORDS) return 0;
    if (size == SZ_HW && addr % 4 == 3) return 0;
    if (size == SZ_W && addr % 4 != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int base;
    base = int'(addr / 4) * 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data);
    int nbytes;
    nbytes = (size == SZ_B) ? 1 : (size == SZ_HW) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
  endtask

  task automatic model_reset();
    wait_m    = 0;
    last_addr = 0;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = 0; exp_err[k] = 0; exp_rd[k] = 0; t_req[k] = 0;
    end
  endtask

  task automatic set_tr(input int k, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    t_req[k] = 1; t_we[k] = we; t_size[k] = size; t_addr[k] = addr; t_wdata[k] = wdata;
  endtask

  // One cycle: entered and left just after a rising edge.
  task automatic step();
    logic g0, g1, leg;
    int   k;
    m0_req = t_req[0]; m0_we = t_we[0]; m0_size = t_size[0];
    m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
    m1_req = t_req[1]; m1_we = t_we[1]; m1_size = t_size[1];
    m1_addr = t_addr[1]; m1_wdata = t_wdata[1];
    @(negedge clk);
    g1 = t_req[1] && (!t_req[0] || wait_m == MAX_WAIT);
    g0 = t_req[0] && !g1;
    obs_g1 = m1_gnt;
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    chk("m0_err", 32'(m0_err), 32'(exp_err[0]));
    chk("m1_err", 32'(m1_err), 32'(exp_err[1]));
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    exp_rv[0] = 0;
    exp_rv[1] = 0;
    if (g0 || g1) begin
      k = g1 ? 1 : 0;
      leg = is_legal(t_size[k], t_addr[k]);
      last_addr = leg ? t_addr[k] : 32'd0;
      chk("ram_we", 32'(ram_we), 32'(leg && t_we[k]));
      if (leg && t_we[k]) begin
        chk("ram_mem_ctrl", 32'(ram_mem_ctrl), 32'(t_size[k]));
        chk("ram_wdata", ram_wdata, t_wdata[k]);
        ref_store(t_size[k], t_addr[k], t_wdata[k]);
      end else begin
        exp_rv[k]  = 1;
        exp_err[k] = !leg;
        exp_rd[k]  = leg ? ref_word(t_addr[k]) : 32'd0;
      end
      t_req[k] = 0;
    end else begin
      chk("ram_we_idle", 32'(ram_we), 32'd0);
    end
    chk("ram_addr", ram_addr, last_addr);
    if (m1_req && !g1) wait_m = (wait_m < 15) ? wait_m + 1 : 15;
    else wait_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tr(input int k);
    logic [1:0]  size;
    logic [31:0] addr;
    size = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 9) == 0) addr = 32'(WORDS * 4 + $urandom_range(0, 4095));
    else addr = 32'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(0, 3));
    else if (size == SZ_HW) addr[1] = 1'($urandom_range(0, 1));
    else if (size == SZ_B) addr[1:0] = 2'($urandom_range(0, 3));
    set_tr(k, 1'($urandom_range(0, 1)), size, addr, $urandom);
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 2; k++) begin
      t_we[k] = 0; t_size[k] = 0; t_addr[k] = 0; t_wdata[k] = 0;
    end

    // Reset: no grants while rst is high, all registered outputs clear.
    m0_req = 1; m0_we = 1; m0_size = SZ_W; m0_addr = 32'h10; m1_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    m1_req = 0;

    // Load granted, then reset in the second half of its cycle: response is dropped.
    m0_we = 0; m0_size = SZ_W; m0_addr = 32'h10;
    @(negedge clk);
    chk("t1_gnt_before_rst", 32'(m0_gnt), 32'd1);
    rst = 1;
    #1;
    chk("t1_gnt_in_rst", 32'(m0_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("t1_m0_err", 32'(m0_err), 32'd0);
    chk("t1_m0_rdata", m0_rdata, 32'd0);
    chk("t1_ram_addr", ram_addr, 32'd0);
    rst = 0;
    model_reset();

    // Store then immediate load of the same word.
    set_tr(0, 1, SZ_W, 32'h10, 32'hDEADBEEF); step();
    set_tr(0, 0, SZ_W, 32'h10, 32'h0);        step();
    chk("t2_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t2_rdata", m0_rdata, 32'hDEADBEEF);
    step();

    // Byte store merges into an existing word.
    set_tr(0, 1, SZ_W, 32'h10, 32'h11223344); step();
    set_tr(0, 1, SZ_B, 32'h11, 32'h000000AA); step();
    set_tr(0, 0, SZ_W, 32'h10, 32'h0);        step();
    chk("t3_rdata", m0_rdata, 32'h1122AA44);
    step();

    // Rejected accesses: misaligned halfword store, out-of-range load.
    set_tr(0, 1, SZ_HW, 32'h13, 32'h0000BEEF); step();
    chk("t5_sh_err", 32'(m0_err), 32'd1);
    chk("t5_sh_rdata", m0_rdata, 32'd0);
    set_tr(0, 0, SZ_W, 32'(4 * WORDS), 32'h0); step();
    chk("t5_lw_err", 32'(m0_err), 32'd1);
    set_tr(0, 0, SZ_W, 32'h10, 32'h0);         step();
    chk("t5_unchanged", m0_rdata, 32'h1122AA44);
    step();

    // Interleaved loads from both masters keep their own words.
    set_tr(1, 1, SZ_W, 32'h20, 32'hA5A50020); step();
    set_tr(0, 1, SZ_W, 32'h24, 32'h5A5A0024); step();
    set_tr(1, 0, SZ_W, 32'h20, 32'h0);        step();
    set_tr(0, 0, SZ_W, 32'h24, 32'h0);        step();
    chk("t6_m1_rdata", m1_rdata, 32'hA5A50020);
    step();
    chk("t6_m0_rdata", m0_rdata, 32'h5A5A0024);
    step();

    // Starvation guard: both masters requesting continuously.
    for (int i = 0; i < 10; i++) begin
      set_tr(0, 0, SZ_W, 32'h20, 32'h0);
      set_tr(1, 0, SZ_W, 32'h24, 32'h0);
      step();
      chk("t4_m1_gnt", 32'(obs_g1), 32'((i == 4) || (i == 9)));
    end
    t_req[0] = 0; t_req[1] = 0;
    step();

    // Random traffic; requests stay asserted until granted.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!t_req[k] && $urandom_range(0, 99) < 60) rand_tr(k);
      end
      step();
    end
    t_req[0] = 0; t_req[1] = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
